// File: rtl/ring_osc_pkg.sv
// Shared types and constants for the ring-oscillator edge counter.
// Holds the FSM encoding and the synchronizer-flush length.
package ring_osc_pkg;

  localparam int unsigned DefWindowW    = 16;
  localparam int unsigned DefCountW     = 16;
  localparam int unsigned DefSyncStages = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StCount  = 2'd2,
    StDone   = 2'd3
  } state_e;

  // SETTLE must outlast the synchronizer plus the edge detector's history flop.
  function automatic int unsigned settle_cycles(int unsigned sync_stages);
    return sync_stages + 1;
  endfunction

  localparam int unsigned DefSettleCycles = settle_cycles(DefSyncStages);

endpackage

// File: rtl/ring_osc_counter_if.sv
// Control and result handshake between the readout logic and ring_osc_counter.
// The master drives start/window/ready; the slave (counter) returns status and result.
interface ring_osc_counter_if
  import ring_osc_pkg::*;
#(
  parameter int unsigned WINDOW_W = DefWindowW,
  parameter int unsigned COUNT_W  = DefCountW
) ();

  logic                start;
  logic [WINDOW_W-1:0] window_cycles;
  logic                busy;
  logic [COUNT_W-1:0]  result;
  logic                result_valid;
  logic                result_ready;
  logic                overflow;

  modport master (
    output start,
    output window_cycles,
    output result_ready,
    input  busy,
    input  result,
    input  result_valid,
    input  overflow
  );

  modport slave (
    input  start,
    input  window_cycles,
    input  result_ready,
    output busy,
    output result,
    output result_valid,
    output overflow
  );

endinterface

// File: rtl/osc_sync_edge.sv
// Multi-flop synchronizer for the asynchronous oscillator bit followed by a
// rising-edge detector producing a one-cycle edge_pulse.
module osc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic osc_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], osc_in};
      r_prev <= w_sync_out;
    end
  end

  assign edge_pulse = w_sync_out & ~r_prev;

endmodule

// File: rtl/ring_osc_counter.sv
// Gates the ring oscillator for a programmed window of clk cycles, counts rising
// edges of one loop bit and returns the saturating count over a valid/ready handshake.
module ring_osc_counter
  import ring_osc_pkg::*;
#(
  parameter int unsigned WINDOW_W    = DefWindowW,
  parameter int unsigned COUNT_W     = DefCountW,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               osc_in,
  output logic               osc_enable,
  ring_osc_counter_if.slave  bus
);

  localparam int unsigned SettleLen = settle_cycles(SYNC_STAGES);
  localparam int unsigned TimerW    = (WINDOW_W > 3) ? WINDOW_W : 3;

  state_e              r_state, w_state_nxt;
  logic                r_armed, w_armed_nxt;
  logic [WINDOW_W-1:0] r_win, w_win_nxt;
  logic [TimerW-1:0]   r_timer, w_timer_nxt;
  logic [COUNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_sat;
  logic                r_overflow, w_overflow_nxt, w_overflow_sat;
  logic [COUNT_W-1:0]  r_result, w_result_nxt;
  logic                w_edge;

  osc_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .osc_in     (osc_in),
    .edge_pulse (w_edge)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_armed    <= 1'b0;
      r_win      <= '0;
      r_timer    <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      r_result   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_armed    <= w_armed_nxt;
      r_win      <= w_win_nxt;
      r_timer    <= w_timer_nxt;
      r_cnt      <= w_cnt_nxt;
      r_overflow <= w_overflow_nxt;
      r_result   <= w_result_nxt;
    end
  end

  // Saturating increment: once at all-ones, further edges only flag overflow.
  always_comb begin
    w_cnt_sat      = r_cnt;
    w_overflow_sat = r_overflow;
    if (w_edge) begin
      if (&r_cnt) begin
        w_overflow_sat = 1'b1;
      end else begin
        w_cnt_sat = r_cnt + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_armed_nxt    = 1'b0;
    w_win_nxt      = r_win;
    w_timer_nxt    = r_timer;
    w_cnt_nxt      = r_cnt;
    w_overflow_nxt = r_overflow;
    w_result_nxt   = r_result;

    unique case (r_state)
      StIdle: begin
        // An accepted start spends one capture cycle in IDLE before enabling the loop.
        if (r_armed) begin
          w_state_nxt = StSettle;
          w_timer_nxt = TimerW'(SettleLen - 1);
        end else if (bus.start) begin
          w_armed_nxt    = 1'b1;
          w_win_nxt      = bus.window_cycles;
          w_cnt_nxt      = '0;
          w_overflow_nxt = 1'b0;
        end
      end
      StSettle: begin
        if (r_timer == '0) begin
          if (r_win == '0) begin
            w_state_nxt  = StDone;
            w_result_nxt = r_cnt;
          end else begin
            w_state_nxt = StCount;
            w_timer_nxt = TimerW'(r_win) - TimerW'(1);
          end
        end else begin
          w_timer_nxt = r_timer - TimerW'(1);
        end
      end
      StCount: begin
        w_cnt_nxt      = w_cnt_sat;
        w_overflow_nxt = w_overflow_sat;
        if (r_timer == '0) begin
          w_state_nxt  = StDone;
          w_result_nxt = w_cnt_sat;
        end else begin
          w_timer_nxt = r_timer - TimerW'(1);
        end
      end
      StDone: begin
        if (bus.result_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign osc_enable       = (r_state == StSettle) || (r_state == StCount);
  assign bus.busy         = (r_state != StIdle);
  assign bus.result_valid = (r_state == StDone);
  assign bus.result       = r_result;
  assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_ring_osc_counter.sv
// Bench for ring_osc_counter: a default-width and a 4-bit-count instance share one
// stimulus; a timing/count model built from edge arithmetic checks both every cycle.
module tb_ring_osc_counter;
  import ring_osc_pkg::*;

  localparam int SS     = int'(DefSyncStages);
  localparam int SmallW = 4;
  localparam int Max0   = 65535;
  localparam int Max1   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        osc = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] win = '0;
  logic        en0, en1;

  ring_osc_counter_if #(.WINDOW_W(16), .COUNT_W(16))     bus0 ();
  ring_osc_counter_if #(.WINDOW_W(16), .COUNT_W(SmallW)) bus1 ();

  assign bus0.start         = start;
  assign bus0.window_cycles = win;
  assign bus0.result_ready  = ready;
  assign bus1.start         = start;
  assign bus1.window_cycles = win;
  assign bus1.result_ready  = ready;

  ring_osc_counter #(.WINDOW_W(16), .COUNT_W(16), .SYNC_STAGES(DefSyncStages)) u_dut0 (
    .clk        (clk),
    .reset      (rst_n),
    .osc_in     (osc),
    .osc_enable (en0),
    .bus        (bus0)
  );

  ring_osc_counter #(.WINDOW_W(16), .COUNT_W(SmallW), .SYNC_STAGES(DefSyncStages)) u_dut1 (
    .clk        (clk),
    .reset      (rst_n),
    .osc_in     (osc),
    .osc_enable (en1),
    .bus        (bus1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Oscillator: half-periods in clk cycles, fixed 2/2 or random 2..6.
  bit osc_rand = 1'b0;
  initial begin
    forever begin
      int h, l;
      h = osc_rand ? int'($urandom_range(6, 2)) : 2;
      l = osc_rand ? int'($urandom_range(6, 2)) : 2;
      @(negedge clk); #1 osc = 1'b1;
      repeat (h - 1) @(negedge clk);
      @(negedge clk); #1 osc = 1'b0;
      repeat (l - 1) @(negedge clk);
    end
  end

  // Model: cyc numbers clk edges; hist holds osc_in as seen at each edge.
  int cyc = 0;
  bit hist [0:65535];
  bit m_active = 1'b0;
  int m_t = 0;
  int m_n = 0;
  int m_last0 = 0;
  int m_last1 = 0;

  // A rise first visible at edge j is counted iff j lies in the SS-shifted window.
  function automatic int rises(input int t, input int n);
    int c;
    c = 0;
    for (int j = t + 1 + SS; j <= t + SS + n; j++) begin
      if (hist[j] && !hist[j-1]) c++;
    end
    return c;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge rst_n) begin
    m_active = 1'b0;
    m_last0  = 0;
    m_last1  = 0;
  end

  always @(posedge clk) begin
    cyc++;
    hist[cyc] = osc;
    if (rst_n) begin
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_t      = cyc;
          m_n      = int'(win);
        end
      end else if ((cyc - 1 >= m_t + 2 + SS + m_n) && ready) begin
        m_active = 1'b0;
        m_last0  = sat(rises(m_t, m_n), Max0);
        m_last1  = sat(rises(m_t, m_n), Max1);
      end
    end
  end

  always @(negedge clk) begin : compare
    bit xb, xe, xv;
    int r;
    xb = m_active && (cyc >= m_t + 1);
    xe = xb && (cyc < m_t + 2 + SS + m_n);
    xv = m_active && (cyc >= m_t + 2 + SS + m_n);
    chk("busy0", int'(bus0.busy), int'(xb));
    chk("busy1", int'(bus1.busy), int'(xb));
    chk("osc_enable0", int'(en0), int'(xe));
    chk("osc_enable1", int'(en1), int'(xe));
    chk("result_valid0", int'(bus0.result_valid), int'(xv));
    chk("result_valid1", int'(bus1.result_valid), int'(xv));
    if (xv) begin
      r = rises(m_t, m_n);
      chk("result0", int'(bus0.result), sat(r, Max0));
      chk("overflow0", int'(bus0.overflow), int'(r > Max0));
      chk("result1", int'(bus1.result), sat(r, Max1));
      chk("overflow1", int'(bus1.overflow), int'(r > Max1));
    end else if (!m_active) begin
      chk("idle_result0", int'(bus0.result), m_last0);
      chk("idle_result1", int'(bus1.result), m_last1);
    end
  end

  // Start a measurement and wait for result_valid; lat counts edges after the start edge.
  task automatic run_meas(input int n, input bit rdy, output int lat, output int en_cnt);
    @(negedge clk); #1 start = 1'b1; win = 16'(n); ready = rdy;
    @(negedge clk); #1 start = 1'b0;
    lat = -1;
    en_cnt = 0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (en0) en_cnt++;
      if (bus0.result_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("wait_result_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    ready = 1'b1;
    repeat (4) @(negedge clk);
    #1 ready = 1'b0;
  endtask

  initial begin
    int lat, en_cnt;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus0.busy), 0);
    chk("rst_osc_enable", int'(en0), 0);
    chk("rst_result_valid", int'(bus0.result_valid), 0);
    chk("rst_result", int'(bus0.result), 0);
    chk("rst_overflow", int'(bus0.overflow), 0);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Period-4 oscillator, 100-cycle window.
    run_meas(100, 1'b1, lat, en_cnt);
    chk("a_latency", lat, 104);
    chk("a_enable_cycles", en_cnt, 103);
    chk("a_result", int'(bus0.result), 25);
    chk("a_overflow", int'(bus0.overflow), 0);
    drain();

    // 50 edges into a 4-bit counter saturate at 15.
    run_meas(200, 1'b1, lat, en_cnt);
    chk("b_latency", lat, 204);
    chk("b_result_wide", int'(bus0.result), 50);
    chk("b_result_small", int'(bus1.result), 15);
    chk("b_overflow_small", int'(bus1.overflow), 1);
    drain();

    // Zero-length window.
    run_meas(0, 1'b1, lat, en_cnt);
    chk("c_latency", lat, 4);
    chk("c_enable_cycles", en_cnt, 3);
    chk("c_result", int'(bus0.result), 0);
    chk("c_overflow", int'(bus0.overflow), 0);
    drain();

    // Back-pressure held in DONE.
    run_meas(12, 1'b0, lat, en_cnt);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("d_hold_valid", int'(bus0.result_valid), 1);
      chk("d_hold_result", int'(bus0.result), 3);
      chk("d_hold_overflow", int'(bus0.overflow), 0);
      chk("d_hold_enable", int'(en0), 0);
    end
    #1 ready = 1'b1;
    @(negedge clk);
    chk("d_busy_after_hs", int'(bus0.busy), 0);
    chk("d_valid_after_hs", int'(bus0.result_valid), 0);
    #1 ready = 1'b0;
    repeat (3) @(negedge clk);

    // Starts in SETTLE, COUNT, DONE and the handshake cycle; window changed mid-COUNT.
    @(negedge clk); #1 start = 1'b1; win = 16'd40; ready = 1'b0;
    @(negedge clk); #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus0.result_valid && lat < 0) lat = k;
      if (k == 50) chk("e_result", int'(bus0.result), 10);
      if (k == 58) chk("e_idle_after_hs", int'(bus0.busy), 0);
      #1;
      start = (k == 2) || (k == 20) || (k == 50) || (k == 55);
      ready = (k == 55);
      if (k == 2) win = 16'd7;
      if (k == 20) win = 16'd3;
    end
    chk("e_latency", lat, 44);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-COUNT, then a fresh measurement.
    @(negedge clk); #1 start = 1'b1; win = 16'd100; ready = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("f_rst_busy", int'(bus0.busy), 0);
    chk("f_rst_osc_enable", int'(en0), 0);
    chk("f_rst_result_valid", int'(bus0.result_valid), 0);
    chk("f_rst_result", int'(bus0.result), 0);
    chk("f_rst_overflow", int'(bus0.overflow), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_meas(100, 1'b1, lat, en_cnt);
    chk("f_latency", lat, 104);
    chk("f_result", int'(bus0.result), 25);
    drain();

    // Randomized phases, starts, windows and back-pressure.
    osc_rand = 1'b1;
    repeat (4000) begin
      @(negedge clk); #1;
      start = ($urandom_range(7, 0) == 0);
      win   = 16'($urandom_range(120, 0));
      ready = ($urandom_range(2, 0) != 0);
    end
    #1 start = 1'b0; ready = 1'b1;
    repeat (300) @(negedge clk);
    chk("final_idle", int'(bus0.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
